slow_mem_responder: RTL and testbench

Responder side of the cache-to-slow-memory line protocol: answers the `mem_read`/`mem_write` requests issued by the I-cache and D-cache with a fixed, parameterised latency and a one-cycle `mem_ready` pulse. It owns a behavioural array of 128-bit lines. It stands in for the slow instruction and data memories around the top-level CHIP, one instance per cache. It also reports protocol violations and keeps transaction counts for the bench.

---
 rtl/slow_mem_if.sv | 20 ++
 rtl/slow_mem_responder.sv | 101 ++++++++++
 tb/tb_slow_mem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/slow_mem_if.sv
// slow_mem_if: cache-to-slow-memory line request/response bundle plus responder status.
interface slow_mem_if;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         proto_err;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;
    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready, proto_err, rd_count, wr_count
    );
    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready, proto_err, rd_count, wr_count
    );
endinterface

// File: rtl/slow_mem_responder.sv
// slow_mem_responder: fixed-latency 128-bit line memory answering cache read/write requests.
module slow_mem_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    slow_mem_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 2);
    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [27:0]           addr_q, addr_d;
    logic [127:0]          wdata_q, wdata_d;
    logic [127:0]          rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  err_q, err_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic [127:0]          mem_array [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  one_req, stable, go_resp, commit_wr, commit_rd;
    always_comb begin
        idx       = bus.mem_addr[DEPTH_LOG2-1:0];
        one_req   = bus.mem_read ^ bus.mem_write;
        stable    = one_req && bus.mem_write == op_wr_q && bus.mem_addr == addr_q &&
                    (!op_wr_q || bus.mem_wdata == wdata_q);
        // Commit uses the live bus: it equals the latched request whenever we get this far.
        go_resp   = (state_q == IDLE && one_req && LATENCY == 1) ||
                    (state_q == BUSY && cnt_q == 8'd0 && stable);
        commit_wr = go_resp && bus.mem_write;
        commit_rd = go_resp && bus.mem_read;
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        ready_d   = go_resp;
        rdata_d   = commit_rd ? mem_array[idx] : rdata_q;
        rd_cnt_d  = rd_cnt_q + 16'(commit_rd);
        wr_cnt_d  = wr_cnt_q + 16'(commit_wr);
        case (state_q)
            IDLE: begin
                err_d = err_q | (bus.mem_read & bus.mem_write);
                if (one_req) begin
                    op_wr_d = bus.mem_write;
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                err_d   = err_q | !stable;
                state_d = !stable ? IDLE : (cnt_q == 8'd0) ? RESP : BUSY;
                cnt_d   = cnt_q - 8'd1;
            end
            RESP: begin
                err_d   = err_q | !stable;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (commit_wr) mem_array[idx] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.proto_err = err_q;
    assign bus.rd_count  = rd_cnt_q;
    assign bus.wr_count  = wr_cnt_q;
endmodule

// File: tb/tb_slow_mem_responder.sv
// tb_slow_mem_responder: random and directed line traffic checked against an array model.
module tb_slow_mem_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_s_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    slow_mem_if m_if();
    slow_mem_responder #(.LATENCY(4), .DEPTH_LOG2(8)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m_if));
    logic [127:0] mdl [256];
    bit           vld [256];
    int           exp_rd = 0;
    int           exp_wr = 0;
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic drive(input bit rd, input bit wr, input logic [27:0] a, input logic [127:0] d);
        m_if.mem_read  = rd;
        m_if.mem_write = wr;
        m_if.mem_addr  = a;
        m_if.mem_wdata = d;
    endtask
    task automatic xact(input bit wr, input logic [27:0] a, input logic [127:0] d);
        int j = -1;
        int k = int'(a % 28'd256);
        @(posedge clk); #1;
        drive(!wr, wr, a, d);
        for (int i = 0; i < 300 && j < 0; i++) begin
            @(negedge clk);
            if (m_if.mem_ready === 1'b1) j = i;
        end
        check($sformatf("lat_%s_%h", wr ? "wr" : "rd", a), j, 4);
        if (wr) begin
            mdl[k] = d;
            vld[k] = 1'b1;
            exp_wr++;
        end else begin
            check($sformatf("rdata_%h", a), m_if.mem_rdata, mdl[k]);
            exp_rd++;
        end
        check("wr_count", m_if.wr_count, exp_wr);
        check("rd_count", m_if.rd_count, exp_rd);
    endtask
    task automatic idle();
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
    endtask
    task automatic watch_no_ready(input string tag);
        int seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_if.mem_ready !== 1'b0) seen++;
        end
        check(tag, seen, 0);
    endtask
    task automatic check_cleared(input string tag);
        check({tag, "_ready"}, m_if.mem_ready, 0);
        check({tag, "_rdata"}, m_if.mem_rdata, 0);
        check({tag, "_err"}, m_if.proto_err, 0);
        check({tag, "_rd"}, m_if.rd_count, 0);
        check({tag, "_wr"}, m_if.wr_count, 0);
    endtask
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 7;
        slow_mem_if s_if();
        slow_mem_responder #(.LATENCY(L), .DEPTH_LOG2(4)) u_sw (.clk(clk), .rst_n(rst_s_n), .bus(s_if));
        logic [127:0] smdl [16];
        bit           svld [16];
        bit           done = 1'b0;
        initial begin
            s_if.mem_read  = 1'b0;
            s_if.mem_write = 1'b0;
            s_if.mem_addr  = '0;
            s_if.mem_wdata = '0;
            wait (rst_s_n === 1'b1);
            for (int n = 0; n < 30; n++) begin
                automatic int            k  = $urandom_range(0, 15);
                automatic bit            wr = !svld[k] || ($urandom_range(0, 1) == 1);
                automatic logic [27:0]   a  = {24'($urandom), 4'(k)};
                automatic logic [127:0]  d  = {$urandom, $urandom, $urandom, $urandom};
                automatic int            j  = -1;
                @(posedge clk); #1;
                s_if.mem_read  = !wr;
                s_if.mem_write = wr;
                s_if.mem_addr  = a;
                s_if.mem_wdata = d;
                for (int i = 0; i < 300 && j < 0; i++) begin
                    @(negedge clk);
                    if (s_if.mem_ready === 1'b1) j = i;
                end
                check($sformatf("sweep_L%0d_lat", L), j, L);
                if (wr) begin
                    smdl[k] = d;
                    svld[k] = 1'b1;
                end else begin
                    check($sformatf("sweep_L%0d_rdata", L), s_if.mem_rdata, smdl[k]);
                end
            end
            @(posedge clk); #1;
            s_if.mem_read  = 1'b0;
            s_if.mem_write = 1'b0;
            done = 1'b1;
        end
    end
    initial begin
        logic [127:0] pat = 128'h0123456789ABCDEF0123456789ABCDEF;
        drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        #2;
        check_cleared("reset");
        @(negedge clk);
        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        xact(1'b1, 28'h0000010, pat);
        xact(1'b0, 28'h0000010, '0);
        xact(1'b1, 28'h0000105, ~pat);
        xact(1'b0, 28'h0000005, '0);
        xact(1'b1, 28'h0000020, {4{32'hA5A5_0020}});
        xact(1'b1, 28'h0000030, {4{32'h5A5A_0030}});
        repeat (40) begin
            automatic int k  = $urandom_range(0, 255);
            automatic bit wr = !vld[k] || ($urandom_range(0, 1) == 1);
            xact(wr, {20'($urandom), 8'(k)}, {$urandom, $urandom, $urandom, $urandom});
        end
        idle();
        @(posedge clk); #1;
        check("err_before_both", m_if.proto_err, 0);
        drive(1'b1, 1'b1, 28'h40, '1);
        @(negedge clk);
        check("err_same_cycle", m_if.proto_err, 0);
        @(negedge clk);
        check("err_both_high", m_if.proto_err, 1);
        idle();
        watch_no_ready("ready_after_both");
        check("wr_after_both", m_if.wr_count, exp_wr);
        check("rd_after_both", m_if.rd_count, exp_rd);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        exp_rd = 0;
        exp_wr = 0;
        check("err_cleared", m_if.proto_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 28'h20, {4{32'hDEAD_BEEF}});
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        m_if.mem_addr = 28'h21;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        check("err_addr_change", m_if.proto_err, 1);
        watch_no_ready("ready_after_abort");
        check("wr_after_abort", m_if.wr_count, 0);
        xact(1'b0, 28'h20, '0);
        idle();
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 28'h30, {4{32'hC0FF_EE30}});
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_cleared("mid_reset");
        drive(1'b0, 1'b0, '0, '0);
        exp_rd = 0;
        exp_wr = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 28'h30, '0);
        xact(1'b1, 28'h30, {4{32'hC0FF_EE30}});
        xact(1'b0, 28'h30, '0);
        idle();
        for (int i = 0; i < 5000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); i++) @(posedge clk);
        check("sweep_done", {g_sw[0].done, g_sw[1].done, g_sw[2].done}, 3'b111);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
